// File: rtl/throw_aim_controller.sv
// rtl/throw_aim_controller.sv - fire-button aiming: x/y ping-pong sweep, throw strobe, turn and game-end tracking
module throw_aim_controller #(
    parameter int unsigned X_MIN     = 2,
    parameter int unsigned X_MAX     = 22,
    parameter int unsigned Y_MIN     = 16,
    parameter int unsigned Y_MAX     = 36,
    parameter int unsigned SWEEP_DIV = 4000000,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned THROWS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fire,
    input  logic [5:0] score0,
    input  logic [5:0] score1,
    output logic [5:0] x,
    output logic [5:0] y,
    output logic       player,
    output logic       valid_pulse,
    output logic [3:0] throws_left,
    output logic       game_over,
    output logic       winner,
    output logic       draw
);
    typedef enum logic [2:0] {AIM_X, AIM_Y, FIRE, HOLD, CHECK, OVER} state_t;

    localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam int PUL_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SWEEP_DIV - 1);
    localparam logic [PUL_W-1:0] PULSE_LAST = PUL_W'(PULSE_LEN - 1);

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div;
    logic [PUL_W-1:0]   pcnt;
    logic               up;
    logic [3:0]         cnt0, cnt1;
    logic               aiming, tick, end_game;
    logic [3:0]         act_cnt, act_cnt_inc, other_cnt;

    // Returns {next_direction_up, next_position}; endpoints reverse without repeating.
    function automatic logic [6:0] sweep(input logic [5:0] pos, input logic [5:0] lo,
                                         input logic [5:0] hi, input logic dir_up);
        logic [6:0] r;
        if (dir_up) r = (pos >= hi) ? {1'b0, pos - 6'd1} : {1'b1, pos + 6'd1};
        else        r = (pos <= lo) ? {1'b1, pos + 6'd1} : {1'b0, pos - 6'd1};
        return r;
    endfunction

    assign aiming      = (state == AIM_X) || (state == AIM_Y);
    assign tick        = aiming && (div == DIV_LAST);
    assign act_cnt     = player ? cnt1 : cnt0;
    assign other_cnt   = player ? cnt0 : cnt1;
    assign act_cnt_inc = act_cnt + 4'd1;
    assign end_game    = (score0 == 6'd0) || (score1 == 6'd0) ||
                         ((act_cnt_inc == 4'(THROWS)) && (other_cnt == 4'(THROWS)));
    assign throws_left = 4'(THROWS) - act_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= AIM_X;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        valid_pulse = 1'b0;
        case (state)
            AIM_X: if (fire) state_nxt = AIM_Y;
            AIM_Y: if (fire) state_nxt = FIRE;
            FIRE: begin
                valid_pulse = 1'b1;
                if (pcnt == PULSE_LAST) state_nxt = HOLD;
            end
            HOLD:  state_nxt = CHECK;
            CHECK: state_nxt = end_game ? OVER : AIM_X;
            OVER:  state_nxt = OVER;
            default: state_nxt = AIM_X;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            pcnt      <= '0;
            up        <= 1'b1;
            x         <= 6'(X_MIN);
            y         <= 6'(Y_MIN);
            player    <= 1'b0;
            cnt0      <= 4'd0;
            cnt1      <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            draw      <= 1'b0;
        end else begin
            if (!aiming || state_nxt != state || tick) div <= '0;
            else                                        div <= div + 1'b1;

            if (state == FIRE && state_nxt == FIRE) pcnt <= pcnt + 1'b1;
            else                                    pcnt <= '0;

            case (state)
                AIM_X: begin
                    if (fire) begin
                        y  <= 6'(Y_MIN);
                        up <= 1'b1;
                    end else if (tick) begin
                        {up, x} <= sweep(x, 6'(X_MIN), 6'(X_MAX), up);
                    end
                end
                AIM_Y: if (!fire && tick) {up, y} <= sweep(y, 6'(Y_MIN), 6'(Y_MAX), up);
                CHECK: begin
                    if (player) cnt1 <= act_cnt_inc;
                    else        cnt0 <= act_cnt_inc;
                    if (end_game) begin
                        game_over <= 1'b1;
                        winner    <= (score1 < score0);
                        draw      <= (score0 == score1);
                    end else begin
                        player <= ~player;
                        x      <= 6'(X_MIN);
                        y      <= 6'(Y_MIN);
                        up     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_throw_aim_controller.sv
// tb/tb_throw_aim_controller.sv - randomized and directed bench for throw_aim_controller
module tb_throw_aim_controller;
    localparam int XMIN = 2, XMAX = 22, YMIN = 16, YMAX = 36;
    localparam int DIV = 2, PL = 2, TH = 2;

    logic       clk = 1'b0, rst_n = 1'b0, fire = 1'b0;
    logic [5:0] score0 = 6'd40, score1 = 6'd45;
    logic [5:0] x, y;
    logic       player, valid_pulse, game_over, winner, draw;
    logic [3:0] throws_left;

    int total = 0, bad = 0;
    // Model: phase 0 aim x, 1 aim y, 2 strobe, 3 hold, 4 check, 5 over
    int m_phase, m_e, m_lx, m_ly, m_p, m_c0, m_c1, m_go, m_win, m_draw;

    throw_aim_controller #(.X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
                           .SWEEP_DIV(DIV), .PULSE_LEN(PL), .THROWS(TH)) dut (
        .clk(clk), .rst_n(rst_n), .fire(fire), .score0(score0), .score1(score1),
        .x(x), .y(y), .player(player), .valid_pulse(valid_pulse),
        .throws_left(throws_left), .game_over(game_over), .winner(winner), .draw(draw));

    always #5 clk = ~clk;

    function automatic int tri_pos(input int lo, input int hi, input int s);
        int span, k;
        span = hi - lo;
        if (span == 0) return lo;
        k = s % (2 * span);
        return (k <= span) ? lo + k : hi - (k - span);
    endfunction

    function automatic int ex_x();
        return (m_phase == 0) ? tri_pos(XMIN, XMAX, m_e / DIV) : m_lx;
    endfunction

    function automatic int ex_y();
        if (m_phase == 0) return YMIN;
        if (m_phase == 1) return tri_pos(YMIN, YMAX, m_e / DIV);
        return m_ly;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_e = 0; m_lx = XMIN; m_ly = YMIN; m_p = 0;
        m_c0 = 0; m_c1 = 0; m_go = 0; m_win = 0; m_draw = 0;
    endtask

    task automatic model_step();
        case (m_phase)
            0: if (fire) begin m_lx = ex_x(); m_phase = 1; m_e = 0; end else m_e++;
            1: if (fire) begin m_ly = ex_y(); m_phase = 2; m_e = 0; end else m_e++;
            2: begin m_e++; if (m_e == PL) begin m_phase = 3; m_e = 0; end end
            3: m_phase = 4;
            4: begin
                if (m_p == 1) m_c1++; else m_c0++;
                if (score0 == 0 || score1 == 0 || (m_c0 == TH && m_c1 == TH)) begin
                    m_go = 1; m_win = (score1 < score0); m_draw = (score0 == score1);
                    m_phase = 5;
                end else begin
                    m_p = 1 - m_p; m_phase = 0; m_e = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Compare at negedge, then advance the model to predict the coming posedge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("x", x, ex_x());
            chk("y", y, ex_y());
            chk("player", player, m_p);
            chk("valid_pulse", valid_pulse, m_phase == 2);
            chk("throws_left", throws_left, TH - (m_p == 1 ? m_c1 : m_c0));
            chk("game_over", game_over, m_go);
            chk("winner", winner, m_win);
            chk("draw", draw, m_draw);
            if (rst_n) model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press();
        fire = 1'b1; cyc(1); fire = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
    endtask

    task automatic wait_phase(input int ph, input string name);
        int n = 0;
        while (m_phase != ph && n < 600) begin cyc(1); n++; end
        if (m_phase != ph) timeout(name);
    endtask

    task automatic aim_x(input int v, input bool_tick);
        int n = 0;
        while (!(m_phase == 0 && ex_x() == v && (!bool_tick || m_e % DIV == DIV - 1)) && n < 600) begin
            cyc(1); n++;
        end
        if (n >= 600) timeout("aim_x");
        else press();
    endtask

    task automatic aim_y(input int v);
        int n = 0;
        while (!(m_phase == 1 && ex_y() == v) && n < 600) begin cyc(1); n++; end
        if (n >= 600) timeout("aim_y");
        else press();
    endtask

    task automatic rand_throw();
        aim_x($urandom_range(XMAX, XMIN), 0);
        aim_y($urandom_range(YMAX, YMIN));
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        chk("reset_x", x, 2); chk("reset_y", y, 16); chk("reset_player", player, 0);
        chk("reset_vp", valid_pulse, 0); chk("reset_tl", throws_left, 2);
        chk("reset_go", game_over, 0);

        cyc(40);
        chk("sweep_x40", x, 22); chk("sweep_y40", y, 16);
        cyc(2);
        chk("sweep_x42", x, 21);

        aim_x(12, 0); aim_y(27);
        wait_phase(2, "fire_entry");
        chk("throw_vp1", valid_pulse, 1); chk("throw_x", x, 12);
        chk("throw_y", y, 27); chk("throw_p", player, 0);
        press();
        chk("throw_vp2", valid_pulse, 1);
        press();
        chk("hold_vp", valid_pulse, 0); chk("hold_x", x, 12);
        chk("hold_y", y, 27); chk("hold_p", player, 0);
        press();
        cyc(1);
        chk("next_p", player, 1); chk("next_x", x, 2);
        chk("next_y", y, 16); chk("next_tl", throws_left, 2);

        aim_x(7, 1);
        chk("tick_fire_x", x, 7);
        aim_y(20);
        wait_phase(0, "turn_back");
        chk("p0_tl", throws_left, 1);

        aim_x(5, 0); aim_y(30);
        aim_x(15, 0); aim_y(17);
        wait_phase(5, "over_40_45");
        chk("go_40_45", game_over, 1); chk("win_40_45", winner, 0); chk("draw_40_45", draw, 0);
        press();
        cyc(4);
        chk("over_no_vp", valid_pulse, 0);

        do_reset();
        score0 = 6'd45; score1 = 6'd45;
        repeat (4) rand_throw();
        wait_phase(5, "over_draw");
        chk("go_draw", game_over, 1); chk("draw_draw", draw, 1); chk("win_draw", winner, 0);

        do_reset();
        score0 = 6'd30; score1 = 6'd20;
        rand_throw();
        wait_phase(0, "early_turn");
        score1 = 6'd0;
        rand_throw();
        wait_phase(5, "over_early");
        chk("go_early", game_over, 1); chk("win_early", winner, 1); chk("draw_early", draw, 0);

        do_reset();
        score0 = 6'd40; score1 = 6'd45;
        rand_throw();
        wait_phase(2, "async_fire");
        rst_n = 1'b0;
        #1;
        chk("async_vp", valid_pulse, 0); chk("async_x", x, 2); chk("async_p", player, 0);
        cyc(1);
        rst_n = 1'b1;

        for (int g = 0; g < 6; g++) begin
            do_reset();
            score0 = 6'($urandom_range(63, 1)); score1 = 6'($urandom_range(63, 1));
            for (int c = 0; c < 1500; c++) begin
                fire = (!fire && $urandom_range(5, 0) == 0);
                if ($urandom_range(99, 0) == 0)
                    score0 = ($urandom_range(3, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                if ($urandom_range(99, 0) == 0)
                    score1 = ($urandom_range(3, 0) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                cyc(1);
            end
            fire = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/throw_aim_controller.md
Name: throw_aim_controller

Overview:
- Upstream stage of score_calculate. Turns one fire button into a locked (x, y) throw coordinate, a valid_pulse strobe and the active player.
- Cursor x ping-pongs automatically; first fire locks x. Cursor y then ping-pongs; second fire locks y and issues the throw.
- Alternates players, counts throws and reads back score0/score1 to declare game over and the winner.

Parameters:
- X_MIN, 2, lower x sweep bound
- X_MAX, 22, upper x sweep bound
- Y_MIN, 16, lower y sweep bound
- Y_MAX, 36, upper y sweep bound
- SWEEP_DIV, 4000000, clk cycles per cursor step (>=1)
- PULSE_LEN, 2, valid_pulse high time in cycles (>=1)
- THROWS, 5, throws per player (1..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fire  in  1  debounced single-cycle button pulse
- score0  in  6  player-0 score from score_calculate
- score1  in  6  player-1 score from score_calculate
- x  out  6  cursor/throw x
- y  out  6  cursor/throw y
- player  out  1  active player
- valid_pulse  out  1  throw strobe to score_calculate; it latches on the falling edge
- throws_left  out  4  remaining throws of the active player
- game_over  out  1  game finished, sticky
- winner  out  1  winning player, valid when game_over=1 and draw=0
- draw  out  1  equal final scores

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n). All state is registered on posedge clk or asserted-low rst_n.
- Reset values:
  - state=AIM_X, x=X_MIN, y=Y_MIN, player=0, valid_pulse=0
  - throws_left=THROWS, both throw counters=0
  - game_over=0, winner=0, draw=0
  - sweep direction=up, divider=0
- States: AIM_X, AIM_Y, FIRE, HOLD, CHECK, OVER.
- Divider: counts 0..SWEEP_DIV-1 in AIM_X and AIM_Y only. tick=1 on the terminal count, then the divider wraps to 0. It clears to 0 on every state change.
- AIM_X:
  - On tick, x steps by ±1. At X_MAX the direction flips to down; at X_MIN it flips to up.
  - Sequence from reset is X_MIN..X_MAX..X_MIN with no repeated endpoint value.
  - fire: x freezes, y=Y_MIN, direction=up, go to AIM_Y.
- AIM_Y: same sweep rules applied to y over Y_MIN..Y_MAX. fire: y freezes, go to FIRE.
- fire and tick in the same cycle: fire wins and locks the pre-tick value.
- FIRE: valid_pulse=1 for exactly PULSE_LEN cycles, then go to HOLD.
- HOLD: valid_pulse=0 for 1 cycle; x, y and player are unchanged. x, y and player are stable from FIRE entry through the end of HOLD.
- CHECK (1 cycle):
  - Increment the active player's throw counter.
  - End condition: score0==0, or score1==0, or both counters == THROWS. If met, go to OVER.
  - Otherwise: toggle player, x=X_MIN, y=Y_MIN, direction=up, go to AIM_X.
- throws_left = THROWS minus the active player's counter; it updates the cycle after CHECK.
- OVER:
  - game_over=1.
  - score0<score1 → winner=0. score1<score0 → winner=1. Equal → draw=1, winner=0.
  - Results are sampled from the scores once on OVER entry. Sticky until rst_n.
- fire is ignored in FIRE, HOLD, CHECK and OVER. It does not queue.
- Reset mid-operation (including with valid_pulse high) forces reset values immediately. valid_pulse drops asynchronously.
- Scores are not owned here; score_calculate is reset by the same system reset.
- Widths: x and y are 6-bit unsigned with no overflow; the sweep is bounded by the parameters. Counters are 4-bit.

Test Plan (SWEEP_DIV=2, PULSE_LEN=2, THROWS=2):
1. Reset: hold rst_n=0, release → x=2, y=16, player=0, valid_pulse=0, throws_left=2, game_over=0.
2. Sweep: no fire for 44 cycles → x steps every 2 cycles 2,3..22, then 21; x=22 after 40 cycles, x=21 after 42; y stays 16.
3. Throw:
   - Stimulus: fire when x=12, then fire when y=27.
   - Required: valid_pulse high exactly 2 cycles with x=12, y=27, player=0; x, y, player still stable the cycle after the fall.
   - Next cycle: player=1, x=2, y=16, throws_left=2.
4. Priority and ignore:
   - fire coincident with tick at x=7 → x locks at 7.
   - fire pulses during FIRE/HOLD → no extra valid_pulse, no state change.
5. Full game: 4 throws with score0=40, score1=45 driven → game_over=1, winner=0, draw=0; a later fire produces no valid_pulse. Repeat with 45/45 → draw=1.
6. Early end and async reset:
   - score1 driven 0 before player 1's first CHECK → game_over=1, winner=1 after 1 throw each.
   - rst_n pulsed low while valid_pulse=1 → valid_pulse=0 without a clock edge, state AIM_X, x=2.
